// File: rtl/data_mem_responder.sv
// Data-memory responder: latches one load/store, waits WAIT_STATES cycles, then pulses memReady for one cycle.
// Latency WAIT_STATES+1 cycles from accept; new requests are ignored while busy.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] memAddr,
    input  logic [31:0] memDataIn,
    input  logic [2:0]  memSize,
    output logic [31:0] memDataOut,
    output logic        memReady,
    output logic        memErr,
    output logic        busy
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WS         = 4'(WAIT_STATES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] addrQ;
    logic [31:0] dataQ;
    logic [2:0]  sizeQ;
    logic        rdQ;
    logic        wrQ;
    logic        errQ;

    logic [31:0] mem [DEPTH_WORDS];

    logic        inIdle;
    logic        accept;
    logic        enterDone;
    logic [31:0] curAddr;
    logic [31:0] curData;
    logic [2:0]  curSize;
    logic        curRd;
    logic        curWr;
    logic        sizeBad;
    logic        misalign;
    logic        outOfRange;
    logic        reqErr;
    logic [AW-1:0] wordIdx;
    logic [31:0] readWord;
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [31:0] loadVal;
    logic [31:0] wrWord;
    logic [3:0]  wrBe;

    assign inIdle = (state == IDLE);
    assign accept = inIdle && (memRead || memWrite);

    // With zero wait states the access completes on the accepting edge, so the
    // operands come straight from the ports rather than the latches.
    assign curAddr = inIdle ? memAddr   : addrQ;
    assign curData = inIdle ? memDataIn : dataQ;
    assign curSize = inIdle ? memSize   : sizeQ;
    assign curRd   = inIdle ? memRead   : rdQ;
    assign curWr   = inIdle ? memWrite  : wrQ;

    assign enterDone = (accept && (WS == 4'd0)) || ((state == WAIT) && (cnt == 4'd1));

    always_comb begin
        sizeBad = 1'b1;
        case (curSize)
            3'b000, 3'b001, 3'b010: sizeBad = 1'b0;
            3'b100, 3'b101:         sizeBad = curWr;
            default:                sizeBad = 1'b1;
        endcase
    end

    assign misalign   = ((curSize[1:0] == 2'b01) && curAddr[0]) ||
                        ((curSize[1:0] == 2'b10) && (curAddr[1:0] != 2'b00));
    assign outOfRange = ({1'b0, curAddr} >= BYTE_LIMIT);
    assign reqErr     = (curRd && curWr) || sizeBad || misalign || outOfRange;

    assign wordIdx  = curAddr[AW+1:2];
    assign readWord = mem[wordIdx];

    always_comb begin
        selByte = readWord[7:0];
        case (curAddr[1:0])
            2'd0: selByte = readWord[7:0];
            2'd1: selByte = readWord[15:8];
            2'd2: selByte = readWord[23:16];
            2'd3: selByte = readWord[31:24];
            default: selByte = readWord[7:0];
        endcase
    end

    assign selHalf = curAddr[1] ? readWord[31:16] : readWord[15:0];

    always_comb begin
        loadVal = readWord;
        case (curSize)
            3'b000:  loadVal = {{24{selByte[7]}}, selByte};
            3'b001:  loadVal = {{16{selHalf[15]}}, selHalf};
            3'b100:  loadVal = {24'h0, selByte};
            3'b101:  loadVal = {16'h0, selHalf};
            default: loadVal = readWord;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the target.
    always_comb begin
        wrWord = curData;
        wrBe   = 4'b1111;
        case (curSize[1:0])
            2'b00: begin
                wrWord = {4{curData[7:0]}};
                wrBe   = 4'b0001 << curAddr[1:0];
            end
            2'b01: begin
                wrWord = {2{curData[15:0]}};
                wrBe   = curAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wrWord = curData;
                wrBe   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addrQ      <= 32'h0;
            dataQ      <= 32'h0;
            sizeQ      <= 3'b000;
            rdQ        <= 1'b0;
            wrQ        <= 1'b0;
            errQ       <= 1'b0;
            memDataOut <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addrQ <= memAddr;
                        dataQ <= memDataIn;
                        sizeQ <= memSize;
                        rdQ   <= memRead;
                        wrQ   <= memWrite;
                        if (WS == 4'd0) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= WS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (enterDone) begin
                errQ <= reqErr;
                if (curRd && !reqErr) begin
                    memDataOut <= loadVal;
                end
            end
        end
    end

    // The array has no reset; a reset on the commit edge drops the store.
    always_ff @(posedge CLK) begin
        if (!RES && enterDone && curWr && !reqErr) begin
            for (int b = 0; b < 4; b++) begin
                if (wrBe[b]) begin
                    mem[wordIdx][8*b +: 8] <= wrWord[8*b +: 8];
                end
            end
        end
    end

    assign memReady = (state == DONE);
    assign memErr   = memReady && errQ;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, hand-written corner sequences, and random traffic vs a byte-array model.
module tb_data_mem_responder;

    localparam int DW = 1024;
    localparam int WS = 2;

    logic        CLK = 1'b0;
    logic        RES;
    logic        rd, wr;
    logic [31:0] addr, dIn;
    logic [2:0]  size;
    logic [31:0] out;
    logic        rdy, err, bsy;

    logic        r0, w0;
    logic [31:0] a0, d0;
    logic [2:0]  s0;
    logic [31:0] out0;
    logic        rdy0, err0, bsy0;

    always #5 CLK = ~CLK;

    data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
        .CLK(CLK), .RES(RES), .memRead(rd), .memWrite(wr), .memAddr(addr),
        .memDataIn(dIn), .memSize(size), .memDataOut(out), .memReady(rdy),
        .memErr(err), .busy(bsy)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
        .CLK(CLK), .RES(RES), .memRead(r0), .memWrite(w0), .memAddr(a0),
        .memDataIn(d0), .memSize(s0), .memDataOut(out0), .memReady(rdy0),
        .memErr(err0), .busy(bsy0)
    );

    int nTests = 0;
    int nFail  = 0;

    logic [7:0]  mdl [256];
    logic [31:0] mdlOut;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        expErr;
        logic [31:0] expOut;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, access width 1<<size[1:0], errors from the access rules.
    task automatic modelOp(input logic r, input logic w, input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] d, output logic e, output logic [31:0] o);
        int     n;
        longint v;
        n = 1 << s[1:0];
        e = (r && w) || (s == 3'd3) || (s == 3'd6) || (s == 3'd7) || (w && s[2]) ||
            (a >= 32'(4*DW)) || ((a % n) != 0);
        if (!e) begin
            if (w) begin
                for (int i = 0; i < n; i++) mdl[int'(a) + i] = d[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (longint'(mdl[int'(a) + i]) << (8*i));
                if (!s[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
                mdlOut = v[31:0];
            end
        end
        o = mdlOut;
    endtask

    // One transaction on dut; inputs are scrambled after accept to prove they are ignored.
    task automatic doReq(input logic r, input logic w, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d, output logic e, output logic [31:0] o);
        int k;
        @(negedge CLK);
        rd = r; wr = w; addr = a; size = s; dIn = d;
        @(posedge CLK); #1;
        check("busy_after_accept", {31'b0, bsy}, 32'd1);
        rd = 1'b0; wr = 1'b0; addr = $urandom; size = 3'($urandom); dIn = $urandom;
        k = 1;
        while (!rdy && k < 20) begin
            @(posedge CLK); #1;
            k++;
        end
        check("ready_latency", k, WS + 1);
        e = err;
        o = out;
        @(posedge CLK); #1;
        check("ready_one_cycle", {30'b0, rdy, bsy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e, eExp;
        logic [31:0] o, oExp;
        logic        sawRdy;
        int          sel;
        logic [31:0] ra;

        vecs[0]  = '{0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 32'h0};
        vecs[1]  = '{1, 0, 32'h10, 3'd2, 32'h0,        0, 32'hDEADBEEF};
        vecs[2]  = '{0, 1, 32'h21, 3'd0, 32'h80,       0, 32'hDEADBEEF};
        vecs[3]  = '{1, 0, 32'h21, 3'd0, 32'h0,        0, 32'hFFFFFF80};
        vecs[4]  = '{1, 0, 32'h21, 3'd4, 32'h0,        0, 32'h00000080};
        vecs[5]  = '{1, 0, 32'h20, 3'd5, 32'h0,        0, 32'h00008000};
        vecs[6]  = '{1, 0, 32'h12, 3'd2, 32'h0,        1, 32'h00008000};
        vecs[7]  = '{0, 1, 32'h13, 3'd1, 32'hFFFF,     1, 32'h00008000};
        vecs[8]  = '{1, 0, 32'(4*DW), 3'd2, 32'h0,     1, 32'h00008000};
        vecs[9]  = '{1, 1, 32'h10, 3'd2, 32'h5555,     1, 32'h00008000};
        vecs[10] = '{1, 0, 32'h10, 3'd2, 32'h0,        0, 32'hDEADBEEF};
        vecs[11] = '{1, 0, 32'h20, 3'd2, 32'h0,        0, 32'h00008000};
        vecs[12] = '{0, 1, 32'h30, 3'd4, 32'h11,       1, 32'h00008000};
        vecs[13] = '{1, 0, 32'h30, 3'd3, 32'h0,        1, 32'h00008000};

        RES = 1'b1;
        rd = 0; wr = 0; addr = 0; dIn = 0; size = 0;
        r0 = 0; w0 = 0; a0 = 0; d0 = 0; s0 = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_out", out, 32'h0);
        check("reset_flags", {29'b0, rdy, err, bsy}, 32'd0);
        check("reset_flags0", {29'b0, rdy0, err0, bsy0}, 32'd0);
        @(negedge CLK);
        RES = 1'b0;

        mdlOut = 32'h0;
        for (int i = 0; i < 256; i++) mdl[i] = 8'h0;
        for (int i = 0; i < 64; i++) doReq(1'b0, 1'b1, 32'(i*4), 3'd2, 32'h0, e, o);

        for (int i = 0; i < 14; i++) begin
            modelOp(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].data, eExp, oExp);
            doReq(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].data, e, o);
            check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].expErr});
            check($sformatf("vec%0d_out", i), o, vecs[i].expOut);
        end

        // Reset during WAIT drops the store and returns to IDLE.
        @(negedge CLK);
        wr = 1'b1; addr = 32'h40; size = 3'd2; dIn = 32'h12345678;
        @(posedge CLK); #1;
        wr = 1'b0;
        check("midrst_busy_before", {31'b0, bsy}, 32'd1);
        @(negedge CLK);
        RES = 1'b1;
        @(posedge CLK); #1;
        check("midrst_busy_after", {30'b0, bsy, rdy}, 32'd0);
        check("midrst_out", out, 32'h0);
        @(negedge CLK);
        RES = 1'b0;
        mdlOut = 32'h0;
        sawRdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            sawRdy = sawRdy | rdy;
        end
        check("midrst_no_ready", {31'b0, sawRdy}, 32'd0);
        modelOp(1'b1, 1'b0, 32'h40, 3'd2, 32'h0, eExp, oExp);
        doReq(1'b1, 1'b0, 32'h40, 3'd2, 32'h0, e, o);
        check("midrst_lw", o, 32'h0);
        check("midrst_lw_err", {31'b0, e}, 32'd0);

        // Reset wins over a simultaneous request.
        modelOp(1'b1, 1'b0, 32'h10, 3'd2, 32'h0, eExp, oExp);
        doReq(1'b1, 1'b0, 32'h10, 3'd2, 32'h0, e, o);
        check("pre_prio_lw", o, 32'hDEADBEEF);
        @(negedge CLK);
        RES = 1'b1; rd = 1'b1; addr = 32'h10; size = 3'd2;
        @(posedge CLK); #1;
        @(negedge CLK);
        RES = 1'b0; rd = 1'b0;
        check("prio_busy", {31'b0, bsy}, 32'd0);
        check("prio_out", out, 32'h0);
        mdlOut = 32'h0;

        // Zero wait states: store, then a held load completes every second cycle.
        @(negedge CLK);
        w0 = 1'b1; a0 = 32'h8; s0 = 3'd2; d0 = 32'hCAFEF00D;
        @(posedge CLK); #1;
        check("zw_store_ready", {31'b0, rdy0}, 32'd1);
        @(negedge CLK);
        w0 = 1'b0; r0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge CLK); #1;
            check($sformatf("zw_ready%0d", i), {31'b0, rdy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (rdy0) begin
                check($sformatf("zw_data%0d", i), out0, 32'hCAFEF00D);
                check($sformatf("zw_err%0d", i), {31'b0, err0}, 32'd0);
            end
        end
        @(negedge CLK);
        r0 = 1'b0;

        for (int t = 0; t < 200; t++) begin
            logic r, w;
            sel = $urandom_range(0, 9);
            r = (sel < 4) || (sel >= 8);
            w = (sel >= 4) && (sel <= 8);
            ra = ($urandom_range(0, 7) == 0) ? 32'(4*DW + $urandom_range(0, 1000))
                                             : 32'($urandom_range(0, 255));
            size = 3'($urandom_range(0, 7));
            dIn = $urandom;
            modelOp(r, w, ra, size, dIn, eExp, oExp);
            doReq(r, w, ra, size, dIn, e, o);
            check($sformatf("rnd%0d_err", t), {31'b0, e}, {31'b0, eExp});
            check($sformatf("rnd%0d_out", t), o, oExp);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the array; the valid byte range is 0 to 4*DEPTH_WORDS-1.
REQ-002 SHALL have parameter WAIT_STATES, default 2, range 0-15, meaning the extra cycles inserted before a response.
REQ-003 SHALL have the port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port RES, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have the port memRead, input, 1 bit: load request from the core.
REQ-006 SHALL have the port memWrite, input, 1 bit: store request from the core.
REQ-007 SHALL have the port memAddr, input, 32 bits: byte address.
REQ-008 SHALL have the port memDataIn, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have the port memSize, input, 3 bits: the RISC-V func3 of the load/store.
REQ-010 SHALL have the port memDataOut, output, 32 bits: load result, sign- or zero-extended.
REQ-011 SHALL have the port memReady, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have the port memErr, output, 1 bit: error flag, valid only while memReady=1.
REQ-013 SHALL have the port busy, output, 1 bit: high while the FSM is not in IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-015 SHALL accept a request in IDLE at a rising edge where memRead|memWrite=1, latching memAddr, memDataIn and memSize.
  - Next state is WAIT when WAIT_STATES>0, otherwise DONE.
REQ-016 SHALL load a down-counter with WAIT_STATES on entry to WAIT, decrement it once per cycle, and move to DONE on the cycle the counter reaches 1.
REQ-017 SHALL assert memReady only while in DONE.
  - memReady is exactly WAIT_STATES+1 cycles after the accepting edge.
  - DONE returns to IDLE unconditionally after one cycle.
  - The earliest next accept is the edge that leaves DONE+1, so back-to-back requests are spaced WAIT_STATES+2 cycles apart.
REQ-018 SHALL ignore memRead, memWrite, memAddr, memDataIn and memSize changes while busy=1; the latched values govern the transaction.
REQ-019 SHALL store little-endian.
  - memSize 000: byte, lanes chosen by addr[1:0].
  - memSize 001: halfword, lanes chosen by addr[1].
  - memSize 010: word.
  - Unselected bytes are unmodified.
REQ-020 SHALL return loads as follows:
  - memSize 000 (lb) and 001 (lh): sign-extended.
  - memSize 100 (lbu) and 101 (lhu): zero-extended.
  - memSize 010 (lw): the full word.
REQ-021 SHALL commit the write on the edge entering DONE, so a read issued next observes the new data.
REQ-022 SHALL update memDataOut on the edge entering DONE for a successful read, and hold it until the next successful read completes; writes and errors SHALL NOT change it.
REQ-023 SHALL flag an error (memErr=1 with memReady) for each of these conditions, with no array update on any error:
  - memRead and memWrite both 1 at accept.
  - A misaligned halfword or word.
  - An address ≥ 4*DEPTH_WORDS.
  - An illegal memSize: 011, 110 or 111 for any access, and additionally 100 or 101 for stores.
REQ-024 SHALL hold memErr=0 whenever memReady=0.
REQ-025 SHALL NOT reset the memory array contents.

Reset
REQ-026 SHALL, on RES=1 at a rising edge and regardless of state, go to IDLE and clear the counter.
  - Outputs after reset: memReady=0, memErr=0, busy=0, memDataOut=32'h0.
REQ-027 SHALL abort any in-flight write when reset occurs before the DONE-entry edge; the array is unchanged.
REQ-028 SHALL give RES priority over a request in the same cycle; the request is not accepted.

Verification
REQ-029 SHALL cover word write then read.
  - Stimulus: WAIT_STATES=2, sw 32'hDEADBEEF to addr 0x10, then lw 0x10.
  - Response: each memReady occurs 3 cycles after accept; the lw returns 32'hDEADBEEF with memErr=0.
REQ-030 SHALL cover byte/half extension.
  - Stimulus: sb 8'h80 to 0x21, then lb 0x21, lbu 0x21, lhu 0x20.
  - Response: lb returns 32'hFFFFFF80, lbu returns 32'h00000080, and lhu returns 32'h0000_80xx, where xx is the previous byte at 0x20.
REQ-031 SHALL cover errors.
  - Stimulus: lw 0x12; then sh to 0x13; then lw to 4*DEPTH_WORDS; then memRead=memWrite=1.
  - Response: each completes with memReady=1, memErr=1; memDataOut is unchanged and the array is unchanged.
REQ-032 SHALL cover zero wait states.
  - Stimulus: WAIT_STATES=0 with back-to-back lw requests held high.
  - Response: memReady pulses every 2nd cycle, 1 cycle after each accept.
REQ-033 SHALL cover reset mid-operation.
  - Stimulus: sw 32'h12345678 to 0x40 (prior content 32'h0), with RES asserted during WAIT.
  - Response: busy=0 next cycle, no memReady, and a subsequent lw 0x40 returns 32'h0.
REQ-034 SHALL cover a busy-ignore case.
  - Stimulus: change memAddr and memSize mid-transaction.
  - Response: the result reflects the originally latched request.
